// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types and constants used by the interrupt controller.
// Holds state encoding, IRQ bit indices and dispatch sequencing constants.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        INT_RUN,
        INT_HALT,
        INT_DISPATCH
    } int_state_t;

    localparam int IRQ_COUNT  = 5;
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_LCD    = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam int DISPATCH_STEPS = 5;

    localparam logic [2:0] STEP_PCL  = 3'd3;
    localparam logic [2:0] STEP_LAST = 3'(DISPATCH_STEPS - 1);

endpackage

// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// Scheduler/register-bus side signals of the interrupt controller.
// master drives requests and strobes, slave is the controller.
interface gb_cpu_interrupt_ctrl_if
    import gb_cpu_common_pkg::*;
#(
    parameter int NUM_IRQ = IRQ_COUNT
) ();

    logic               boundary_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic               ie_wr_i;
    logic               if_wr_i;
    logic [7:0]         reg_wdata_i;
    logic               ei_i;
    logic               di_i;
    logic               reti_i;
    logic               halt_i;
    logic [7:0]         ie_o;
    logic [7:0]         if_o;
    logic               ime_o;
    logic               halted_o;
    logic               halt_bug_o;
    logic               dispatch_o;
    logic [2:0]         dispatch_step_o;
    logic [7:0]         vector_o;

    modport master (
        output boundary_i, irq_i, ie_wr_i, if_wr_i, reg_wdata_i,
        output ei_i, di_i, reti_i, halt_i,
        input  ie_o, if_o, ime_o, halted_o, halt_bug_o,
        input  dispatch_o, dispatch_step_o, vector_o
    );

    modport slave (
        input  boundary_i, irq_i, ie_wr_i, if_wr_i, reg_wdata_i,
        input  ei_i, di_i, reti_i, halt_i,
        output ie_o, if_o, ime_o, halted_o, halt_bug_o,
        output dispatch_o, dispatch_step_o, vector_o
    );

endinterface

// File: rtl/gb_cpu_irq_priority.sv
// Fixed-priority interrupt arbiter: lowest set pending bit wins.
// Purely combinational; produces the bit index and its jump vector.
module gb_cpu_irq_priority #(
    parameter int         NUM_IRQ       = 5,
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'd8
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [2:0]         idx,
    output logic [7:0]         vector
);

    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) idx = 3'(i);
        end
    end

    assign valid  = |pending;
    assign vector = VECTOR_BASE + VECTOR_STRIDE * {5'd0, idx};

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// IE/IF/IME ownership, EI delay, HALT and the 5 M-cycle dispatch.
// Runs on the M-clock and overrides the scheduler while dispatching.
module gb_cpu_interrupt_ctrl
    import gb_cpu_common_pkg::*;
#(
    parameter int         NUM_IRQ       = IRQ_COUNT,
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'd8
) (
    input logic                    clk,
    input logic                    reset,
    gb_cpu_interrupt_ctrl_if.slave bus
);

    int_state_t         state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [7:0]         ie_q;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic               ime_q, ime_d;
    logic               eip_q, eip_d;
    logic               bug_q, bug_d;
    logic [7:0]         vec_q, vec_d;

    logic [NUM_IRQ-1:0] pending;
    logic               any_pending;
    logic               ime_eff;
    logic               at_pcl;
    logic               take;
    logic               arb_valid;
    logic [2:0]         arb_idx;
    logic [7:0]         arb_vec;
    logic [7:0]         sel_vec;

    assign pending     = ie_q[NUM_IRQ-1:0] & if_q;
    assign any_pending = |pending;
    // IME as seen by this boundary: a maturing EI or RETI counts, DI vetoes
    assign ime_eff     = (ime_q | eip_q | bus.reti_i) & ~bus.di_i;
    assign at_pcl      = (state_q == INT_DISPATCH) && (step_q == STEP_PCL);
    assign sel_vec     = arb_valid ? arb_vec : 8'h00;

    gb_cpu_irq_priority #(
        .NUM_IRQ       (NUM_IRQ),
        .VECTOR_BASE   (VECTOR_BASE),
        .VECTOR_STRIDE (VECTOR_STRIDE)
    ) u_prio (
        .pending (pending),
        .valid   (arb_valid),
        .idx     (arb_idx),
        .vector  (arb_vec)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        bug_d   = 1'b0;
        vec_d   = vec_q;
        take    = 1'b0;
        ime_d   = ime_q;
        eip_d   = bus.ei_i | (eip_q & ~bus.boundary_i);
        if (bus.boundary_i && eip_q) ime_d = 1'b1;
        if (bus.reti_i) ime_d = 1'b1;
        if (bus.di_i) begin
            ime_d = 1'b0;
            eip_d = 1'b0;
        end
        unique case (state_q)
            INT_RUN: begin
                if (bus.boundary_i && ime_eff && any_pending) begin
                    state_d = INT_DISPATCH;
                    step_d  = '0;
                    take    = 1'b1;
                end else if (bus.boundary_i && bus.halt_i) begin
                    if (!ime_eff && any_pending) bug_d = 1'b1;
                    else state_d = INT_HALT;
                end
            end
            INT_HALT: begin
                if (any_pending) begin
                    step_d = '0;
                    if (ime_q) begin
                        state_d = INT_DISPATCH;
                        take    = 1'b1;
                    end else begin
                        state_d = INT_RUN;
                    end
                end
            end
            INT_DISPATCH: begin
                step_d = step_q + 3'd1;
                if (at_pcl) vec_d = sel_vec;
                if (step_q == STEP_LAST) begin
                    state_d = INT_RUN;
                    step_d  = '0;
                end
            end
            default: state_d = INT_RUN;
        endcase
        if (take) begin
            ime_d = 1'b0;
            eip_d = 1'b0;
        end
    end

    // request pulses are ORed in last so a same-cycle set always wins
    always_comb begin
        if_d = if_q;
        if (bus.if_wr_i) if_d = bus.reg_wdata_i[NUM_IRQ-1:0];
        if (at_pcl && arb_valid) if_d[arb_idx] = 1'b0;
        if_d = if_d | bus.irq_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INT_RUN;
            step_q  <= '0;
            ie_q    <= '0;
            if_q    <= '0;
            ime_q   <= 1'b0;
            eip_q   <= 1'b0;
            bug_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (bus.ie_wr_i) ie_q <= bus.reg_wdata_i;
            if_q    <= if_d;
            ime_q   <= ime_d;
            eip_q   <= eip_d;
            bug_q   <= bug_d;
            vec_q   <= vec_d;
        end
    end

    assign bus.ie_o            = ie_q;
    assign bus.if_o            = {{(8 - NUM_IRQ){1'b1}}, if_q};
    assign bus.ime_o           = ime_q;
    assign bus.halted_o        = (state_q == INT_HALT);
    assign bus.halt_bug_o      = bug_q;
    assign bus.dispatch_o      = (state_q == INT_DISPATCH);
    assign bus.dispatch_step_o = step_q;
    assign bus.vector_o        = at_pcl ? sel_vec : vec_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed and randomized checks of gb_cpu_interrupt_ctrl against
// an abstract IE/IF model with priority computed from the bit rules.
module tb_gb_cpu_interrupt_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] ie_m;
    logic [4:0] if_m;

    gb_cpu_interrupt_ctrl_if #(.NUM_IRQ(5)) bus ();

    gb_cpu_interrupt_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_vec(input logic [4:0] p);
        for (int i = 0; i < 5; i++)
            if (p[i]) return 8'h40 + 8'(8 * i);
        return 8'h00;
    endfunction

    function automatic logic [4:0] clr_lowest(input logic [4:0] p,
                                              input logic [4:0] f);
        for (int i = 0; i < 5; i++)
            if (p[i]) return f & ~(5'd1 << i);
        return f;
    endfunction

    task automatic idle();
        bus.boundary_i  = 0;
        bus.irq_i       = 0;
        bus.ie_wr_i     = 0;
        bus.if_wr_i     = 0;
        bus.reg_wdata_i = 0;
        bus.ei_i        = 0;
        bus.di_i        = 0;
        bus.reti_i      = 0;
        bus.halt_i      = 0;
    endtask

    task automatic wr_ie(input logic [7:0] v);
        bus.ie_wr_i = 1; bus.reg_wdata_i = v;
        cyc();
        bus.ie_wr_i = 0;
        ie_m = v;
    endtask

    task automatic wr_if(input logic [7:0] v, input logic [4:0] irq);
        bus.if_wr_i = 1; bus.reg_wdata_i = v; bus.irq_i = irq;
        cyc();
        bus.if_wr_i = 0; bus.irq_i = 0;
        if_m = v[4:0] | irq;
    endtask

    task automatic pulse_irq(input logic [4:0] irq);
        bus.irq_i = irq;
        cyc();
        bus.irq_i = 0;
        if_m = if_m | irq;
    endtask

    task automatic set_ime();
        bus.reti_i = 1;
        cyc();
        bus.reti_i = 0;
    endtask

    task automatic clr_ime();
        bus.di_i = 1;
        cyc();
        bus.di_i = 0;
    endtask

    task automatic bnd();
        bus.boundary_i = 1;
        cyc();
        bus.boundary_i = 0;
    endtask

    // called on the first dispatch cycle (step 0)
    task automatic walk(input string tag, input logic [4:0] irq1);
        logic [4:0] p;
        for (int s = 0; s < 5; s++) begin
            chk({tag, ":disp"}, 32'(bus.dispatch_o), 1);
            chk({tag, ":step"}, 32'(bus.dispatch_step_o), s);
            if (s == 1) bus.irq_i = irq1;
            if (s == 3) begin
                p = ie_m[4:0] & if_m;
                chk({tag, ":vec"}, 32'(bus.vector_o), 32'(exp_vec(p)));
                if_m = clr_lowest(p, if_m);
            end
            cyc();
            bus.irq_i = 0;
            if (s == 1) if_m = if_m | irq1;
        end
        chk({tag, ":end"}, 32'(bus.dispatch_o), 0);
        chk({tag, ":ime"}, 32'(bus.ime_o), 0);
        chk({tag, ":if"}, 32'(bus.if_o), 32'({3'b111, if_m}));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":ie"}, 32'(bus.ie_o), 0);
        chk({tag, ":if"}, 32'(bus.if_o), 32'hE0);
        chk({tag, ":ime"}, 32'(bus.ime_o), 0);
        chk({tag, ":halt"}, 32'(bus.halted_o), 0);
        chk({tag, ":bug"}, 32'(bus.halt_bug_o), 0);
        chk({tag, ":disp"}, 32'(bus.dispatch_o), 0);
        chk({tag, ":step"}, 32'(bus.dispatch_step_o), 0);
        chk({tag, ":vec"}, 32'(bus.vector_o), 0);
    endtask

    initial begin
        logic [7:0] rv;
        logic [7:0] rw;
        logic [4:0] ri;
        logic [4:0] r1;
        int         n;
        idle();
        ie_m = 0;
        if_m = 0;
        cyc();
        cyc();
        reset = 0;
        chk_reset("rst");

        // single timer request
        wr_ie(8'h04);
        set_ime();
        chk("t1_ime", 32'(bus.ime_o), 1);
        pulse_irq(5'h04);
        chk("t1_if", 32'(bus.if_o), 32'hE4);
        chk("t1_pre", 32'(bus.dispatch_o), 0);
        bnd();
        walk("t1", 5'h00);
        chk("t1_vhold", 32'(bus.vector_o), 32'h50);

        // priority among several pending bits
        wr_ie(8'h1F);
        wr_if(8'h1A, 5'h00);
        set_ime();
        bnd();
        walk("t2", 5'h00);
        chk("t2_if", 32'(bus.if_o), 32'hF8);

        // EI delay
        bus.ei_i = 1; bus.boundary_i = 1;
        cyc();
        bus.ei_i = 0; bus.boundary_i = 0;
        chk("ei_nodisp", 32'(bus.dispatch_o), 0);
        chk("ei_ime", 32'(bus.ime_o), 0);
        bnd();
        walk("ei", 5'h00);
        chk("ei_if", 32'(bus.if_o), 32'hF0);

        // EI;DI
        bus.ei_i = 1; bus.boundary_i = 1;
        cyc();
        bus.ei_i = 0; bus.di_i = 1;
        cyc();
        bus.di_i = 0; bus.boundary_i = 0;
        chk("eidi_disp", 32'(bus.dispatch_o), 0);
        chk("eidi_ime", 32'(bus.ime_o), 0);
        bnd();
        chk("eidi_disp2", 32'(bus.dispatch_o), 0);
        chk("eidi_ime2", 32'(bus.ime_o), 0);

        // HALT with IME=0, wake without dispatch
        wr_if(8'h00, 5'h00);
        wr_ie(8'h01);
        bus.halt_i = 1; bus.boundary_i = 1;
        cyc();
        bus.halt_i = 0; bus.boundary_i = 0;
        chk("halt_on", 32'(bus.halted_o), 1);
        chk("halt_nobug", 32'(bus.halt_bug_o), 0);
        cyc();
        chk("halt_stay", 32'(bus.halted_o), 1);
        pulse_irq(5'h01);
        n = 0;
        while (bus.halted_o === 1'b1 && n < 4) begin
            cyc();
            n++;
        end
        chk("halt_exit", 32'(bus.halted_o), 0);
        chk("halt_nodisp", 32'(bus.dispatch_o), 0);
        chk("halt_if", 32'(bus.if_o), 32'hE1);

        // HALT bug
        bus.halt_i = 1; bus.boundary_i = 1;
        cyc();
        bus.halt_i = 0; bus.boundary_i = 0;
        chk("bug_halt", 32'(bus.halted_o), 0);
        chk("bug_pulse", 32'(bus.halt_bug_o), 1);
        cyc();
        chk("bug_clear", 32'(bus.halt_bug_o), 0);
        chk("bug_halt2", 32'(bus.halted_o), 0);

        // IE overwritten during the PCH push
        set_ime();
        bnd();
        chk("ovr_disp", 32'(bus.dispatch_o), 1);
        cyc();
        cyc();
        chk("ovr_step2", 32'(bus.dispatch_step_o), 2);
        bus.ie_wr_i = 1; bus.reg_wdata_i = 8'h00;
        cyc();
        bus.ie_wr_i = 0;
        ie_m = 8'h00;
        chk("ovr_step3", 32'(bus.dispatch_step_o), 3);
        chk("ovr_vec", 32'(bus.vector_o), 0);
        cyc();
        cyc();
        chk("ovr_end", 32'(bus.dispatch_o), 0);
        chk("ovr_if", 32'(bus.if_o), 32'hE1);
        chk("ovr_vhold", 32'(bus.vector_o), 0);

        // asynchronous reset mid-dispatch
        wr_ie(8'h01);
        set_ime();
        bnd();
        cyc();
        cyc();
        chk("ar_step2", 32'(bus.dispatch_step_o), 2);
        #2;
        reset = 1;
        #1;
        chk_reset("ar");
        cyc();
        reset = 0;
        ie_m = 0;
        if_m = 0;

        // randomized register traffic and dispatches
        for (int t = 0; t < 40; t++) begin
            rv = 8'($urandom);
            rw = 8'($urandom);
            ri = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
            r1 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
            wr_ie(rv);
            wr_if(rw, ri);
            chk("rnd_ie", 32'(bus.ie_o), 32'(ie_m));
            chk("rnd_if", 32'(bus.if_o), 32'({3'b111, if_m}));
            set_ime();
            chk("rnd_ime", 32'(bus.ime_o), 1);
            bnd();
            if ((ie_m[4:0] & if_m) != 5'h00) begin
                walk("rnd", r1);
            end else begin
                chk("rnd_nodisp", 32'(bus.dispatch_o), 0);
                clr_ime();
                chk("rnd_di", 32'(bus.ime_o), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
